// File: rtl/rx_frame_fifo_writer_pkg.sv
// Shared definitions for the RX frame FIFO writer.
// Word layout, writer states and the frame terminator word.
package rx_frame_fifo_writer_pkg;

   localparam int WORD_W  = 10;
   localparam int EOF_BIT = 9;
   localparam int ERR_BIT = 8;

   // Terminator: eof=1, err=1, byte=0x00
   localparam logic [WORD_W-1:0] TERM_WORD = 10'h300;

   typedef enum logic [1:0] {
      IDLE,
      PASS,
      TERM,
      DISCARD
   } wrState_t;

   function automatic logic [WORD_W-1:0] mkWord(
      input logic       eof,
      input logic       err,
      input logic [7:0] dat
   );
      logic [WORD_W-1:0] w;
      w          = '0;
      w[EOF_BIT] = eof;
      w[ERR_BIT] = err;
      w[7:0]     = dat;
      return w;
   endfunction

endpackage

// File: rtl/rx_frame_fifo_writer_sat_counter.sv
// Saturating statistics counter.
// Clear wins over a same-cycle increment.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             WrClk,
   input  logic             Reset,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   // Count up, hold at all-ones, clear on request
   always_ff @(posedge WrClk or posedge Reset) begin
      if (Reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/rx_frame_fifo_writer.sv
// Admission controller writing tagged MAC RX bytes into the data FIFO.
// Every admitted frame is closed by exactly one EOF-tagged word.
module rx_frame_fifo_writer
   import rx_frame_fifo_writer_pkg::*;
#(
   parameter int FIFO_DEPTH = 512,
   parameter int AW         = $clog2(FIFO_DEPTH),
   parameter int MAX_FRAME  = 1522,
   parameter int GUARD      = 4,
   parameter int CNT_W      = 16
) (
   input  logic              WrClk,
   input  logic              Reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   input  logic              in_sof,
   input  logic              in_eof,
   input  logic              in_err,
   input  logic              fifo_full,
   input  logic [AW-1:0]     fifo_wr_num,
   output logic              fifo_wr_en,
   output logic [WORD_W-1:0] fifo_wr_data,
   input  logic              stat_clr,
   output logic [CNT_W-1:0]  cnt_ok,
   output logic [CNT_W-1:0]  cnt_err,
   output logic [CNT_W-1:0]  cnt_drop
);

   localparam int BW = $clog2(MAX_FRAME + 1);

   // Fill limit evaluated modulo 2^(AW+1)
   localparam logic [AW:0] ADMIT_MAX =
      (AW+1)'(FIFO_DEPTH - 1 - MAX_FRAME - GUARD);

   localparam logic [BW-1:0] MAX_CNT = BW'(MAX_FRAME);

   wrState_t          state;
   wrState_t          stateD;
   logic [BW-1:0]     byteCnt;
   logic [BW-1:0]     byteCntD;
   logic [BW-1:0]     byteInc;
   logic              termEof;
   logic              termEofD;
   logic              wrEnD;
   logic [WORD_W-1:0] wrDataD;
   logic              incOk;
   logic              incErr;
   logic              incDrop;
   logic              admit;
   logic              startCase;

   assign admit = !fifo_full &&
                  ({1'b0, fifo_wr_num} <= ADMIT_MAX);

   assign byteInc = byteCnt + 1'b1;

   // A new frame may start from IDLE, or from DISCARD on sof
   assign startCase = (state == IDLE) ||
                      ((state == DISCARD) && in_valid && in_sof);

   // Next state, next FIFO word and counter strobes
   always_comb begin
      stateD   = state;
      byteCntD = byteCnt;
      termEofD = termEof;
      wrEnD    = 1'b0;
      wrDataD  = fifo_wr_data;
      incOk    = 1'b0;
      incErr   = 1'b0;
      incDrop  = 1'b0;
      if (startCase) begin
         if (in_valid && in_sof) begin
            if (admit) begin
               wrEnD    = 1'b1;
               wrDataD  = mkWord(in_eof, in_eof & in_err, in_data);
               byteCntD = BW'(1);
               if (in_eof) begin
                  stateD = IDLE;
                  incOk  = !in_err;
                  incErr = in_err;
               end else begin
                  stateD = PASS;
               end
            end else begin
               incDrop = 1'b1;
               stateD  = in_eof ? IDLE : DISCARD;
            end
         end
      end else begin
         case (state)
            PASS: begin
               if (in_valid) begin
                  if (fifo_full) begin
                     stateD   = TERM;
                     termEofD = in_eof;
                  end else if (in_sof) begin
                     wrEnD   = 1'b1;
                     wrDataD = TERM_WORD;
                     incErr  = 1'b1;
                     incDrop = 1'b1;
                     stateD  = in_eof ? IDLE : DISCARD;
                  end else begin
                     wrEnD    = 1'b1;
                     byteCntD = byteInc;
                     if (in_eof) begin
                        wrDataD = mkWord(1'b1, in_err, in_data);
                        incOk   = !in_err;
                        incErr  = in_err;
                        stateD  = IDLE;
                     end else if (byteInc == MAX_CNT) begin
                        wrDataD = mkWord(1'b1, 1'b1, in_data);
                        incErr  = 1'b1;
                        stateD  = DISCARD;
                     end else begin
                        wrDataD = mkWord(1'b0, 1'b0, in_data);
                     end
                  end
               end
            end
            TERM: begin
               if (in_valid && in_eof) begin
                  termEofD = 1'b1;
               end
               if (!fifo_full) begin
                  wrEnD    = 1'b1;
                  wrDataD  = TERM_WORD;
                  incErr   = 1'b1;
                  termEofD = 1'b0;
                  if (termEof || (in_valid && in_eof)) begin
                     stateD = IDLE;
                  end else begin
                     stateD = DISCARD;
                  end
               end
            end
            DISCARD: begin
               if (in_valid && in_eof) begin
                  stateD = IDLE;
               end
            end
            default: begin
               stateD = IDLE;
            end
         endcase
      end
   end

   // State, byte count and registered FIFO write port
   always_ff @(posedge WrClk or posedge Reset) begin
      if (Reset) begin
         state        <= IDLE;
         byteCnt      <= '0;
         termEof      <= 1'b0;
         fifo_wr_en   <= 1'b0;
         fifo_wr_data <= '0;
      end else begin
         state        <= stateD;
         byteCnt      <= byteCntD;
         termEof      <= termEofD;
         fifo_wr_en   <= wrEnD;
         fifo_wr_data <= wrDataD;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) uCntOk (
      .WrClk (WrClk),
      .Reset (Reset),
      .inc   (incOk),
      .clr   (stat_clr),
      .cnt   (cnt_ok)
   );

   sat_counter #(.CNT_W(CNT_W)) uCntErr (
      .WrClk (WrClk),
      .Reset (Reset),
      .inc   (incErr),
      .clr   (stat_clr),
      .cnt   (cnt_err)
   );

   sat_counter #(.CNT_W(CNT_W)) uCntDrop (
      .WrClk (WrClk),
      .Reset (Reset),
      .inc   (incDrop),
      .clr   (stat_clr),
      .cnt   (cnt_drop)
   );

endmodule

// File: tb/tb_rx_frame_fifo_writer.sv
// Randomized bench for rx_frame_fifo_writer with a frame-level model.
// Directed frames pin the model with literal expectations.
module tb_rx_frame_fifo_writer;

   localparam int FD = 512;
   localparam int AW = 9;
   localparam int MF = 1522;
   localparam int GD = 4;
   localparam int CW = 8;
   localparam int CMAX = (1 << CW) - 1;

   logic          WrClk = 1'b0;
   logic          Reset = 1'b0;
   logic          in_valid = 1'b0;
   logic [7:0]    in_data = '0;
   logic          in_sof = 1'b0;
   logic          in_eof = 1'b0;
   logic          in_err = 1'b0;
   logic          fifo_full = 1'b0;
   logic [AW-1:0] fifo_wr_num = '0;
   logic          fifo_wr_en;
   logic [9:0]    fifo_wr_data;
   logic          stat_clr = 1'b0;
   logic [CW-1:0] cnt_ok;
   logic [CW-1:0] cnt_err;
   logic [CW-1:0] cnt_drop;

   always #5 WrClk = ~WrClk;

   rx_frame_fifo_writer #(
      .FIFO_DEPTH (FD),
      .MAX_FRAME  (MF),
      .GUARD      (GD),
      .CNT_W      (CW)
   ) dut (
      .WrClk        (WrClk),
      .Reset        (Reset),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_sof       (in_sof),
      .in_eof       (in_eof),
      .in_err       (in_err),
      .fifo_full    (fifo_full),
      .fifo_wr_num  (fifo_wr_num),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_wr_data (fifo_wr_data),
      .stat_clr     (stat_clr),
      .cnt_ok       (cnt_ok),
      .cnt_err      (cnt_err),
      .cnt_drop     (cnt_drop)
   );

   int nVec = 0;
   int nBad = 0;
   int thr;
   int wrCnt = 0;
   logic [9:0] lastData = '0;

   // Model: what the frame writer owes the FIFO
   bit inFrame;
   bit waitTerm;
   bit skipping;
   bit sawEof;
   int len;
   int mOk, mErr, mDrop;
   bit nEn;
   logic [9:0] nData;

   bit expEn;
   logic [9:0] expData;
   int expOk, expErr, expDrop;

   bit gFull = 0;
   int gNum = 0;
   bit gClr = 0;

   // Model results become visible one edge after the inputs
   always @(posedge WrClk or posedge Reset) begin
      if (Reset) begin
         expEn   <= 0;
         expData <= '0;
         expOk   <= 0;
         expErr  <= 0;
         expDrop <= 0;
      end else begin
         expEn   <= nEn;
         expData <= nData;
         expOk   <= mOk;
         expErr  <= mErr;
         expDrop <= mDrop;
      end
   end

   function automatic int satAdd(input int a, input int b);
      return (a + b > CMAX) ? CMAX : a + b;
   endfunction

   task automatic lit(input string nm, input int act, input int req);
      nVec++;
      if (act != req) begin
         nBad++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
                  nm, act, act, req, req);
      end
   endtask

   task automatic checkOutputs();
      lit("wr_en", int'(fifo_wr_en), int'(expEn));
      if (expEn) lit("wr_data", int'(fifo_wr_data), int'(expData));
      lit("cnt_ok", int'(cnt_ok), expOk);
      lit("cnt_err", int'(cnt_err), expErr);
      lit("cnt_drop", int'(cnt_drop), expDrop);
      if (fifo_wr_en) begin
         wrCnt++;
         lastData = fifo_wr_data;
      end
   endtask

   task automatic tick();
      @(negedge WrClk);
      checkOutputs();
   endtask

   // Apply one input cycle and work out what it must produce
   task automatic step(input bit v, input logic [7:0] d,
                       input bit s, input bit e, input bit er);
      bit adm;
      bit w;
      logic [9:0] wd;
      int ok, bad, dr;
      in_valid    = v;
      in_data     = d;
      in_sof      = s;
      in_eof      = e;
      in_err      = er;
      fifo_full   = gFull;
      fifo_wr_num = AW'(gNum);
      stat_clr    = gClr;
      adm = !gFull && (gNum <= thr);
      w = 0; wd = '0; ok = 0; bad = 0; dr = 0;
      if (inFrame) begin
         if (v && gFull) begin
            inFrame = 0; waitTerm = 1; sawEof = e;
         end else if (v && s) begin
            w = 1; wd = 10'h300; bad = 1; dr = 1;
            inFrame = 0; skipping = !e;
         end else if (v) begin
            len++;
            w = 1;
            if (e) begin
               wd = {1'b1, er, d};
               if (er) bad = 1; else ok = 1;
               inFrame = 0;
            end else if (len == MF) begin
               wd = {2'b11, d}; bad = 1;
               inFrame = 0; skipping = 1;
            end else begin
               wd = {2'b00, d};
            end
         end
      end else if (waitTerm) begin
         if (v && e) sawEof = 1;
         if (!gFull) begin
            w = 1; wd = 10'h300; bad = 1;
            waitTerm = 0; skipping = !sawEof;
         end
      end else if (v && s) begin
         skipping = 0;
         if (adm) begin
            w = 1; wd = {e, e & er, d}; len = 1;
            if (e) begin
               if (er) bad = 1; else ok = 1;
            end else begin
               inFrame = 1;
            end
         end else begin
            dr = 1; skipping = !e;
         end
      end else if (skipping && v && e) begin
         skipping = 0;
      end
      if (gClr) begin
         mOk = 0; mErr = 0; mDrop = 0;
      end else begin
         mOk = satAdd(mOk, ok);
         mErr = satAdd(mErr, bad);
         mDrop = satAdd(mDrop, dr);
      end
      nEn = w;
      if (w) nData = wd;
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, 0);
   endtask

   task automatic clearStats();
      gClr = 1; idle(1); gClr = 0; idle(1);
   endtask

   task automatic doReset();
      Reset = 1;
      inFrame = 0; waitTerm = 0; skipping = 0; sawEof = 0; len = 0;
      mOk = 0; mErr = 0; mDrop = 0; nEn = 0; nData = '0;
      in_valid = 0; in_sof = 0; in_eof = 0;
      tick();
      tick();
      Reset = 0;
      tick();
   endtask

   task automatic sendFrame(input int n, input bit er);
      for (int i = 1; i <= n; i++)
         step(1, 8'($urandom), i == 1, i == n, er && (i == n));
   endtask

   int w0;

   initial begin
      thr = ((FD - 1 - MF - GD) % (1 << (AW + 1)) + (1 << (AW + 1)))
            % (1 << (AW + 1));
      doReset();
      lit("rst_wr_en", int'(fifo_wr_en), 0);
      lit("rst_wr_data", int'(fifo_wr_data), 0);
      lit("rst_cnt_ok", int'(cnt_ok), 0);
      lit("thr", thr, 9);

      // 64-byte good frame into an empty FIFO
      gNum = 0; w0 = wrCnt;
      sendFrame(64, 0); idle(2);
      lit("f64_writes", wrCnt - w0, 64);
      lit("f64_last_tag", int'(lastData[9:8]), 2);
      lit("f64_ok", int'(cnt_ok), 1);

      // One above the admission limit: dropped, next admitted
      clearStats();
      gNum = 10; w0 = wrCnt;
      sendFrame(20, 0); idle(2);
      lit("drop_writes", wrCnt - w0, 0);
      lit("drop_cnt", int'(cnt_drop), 1);
      gNum = 0; w0 = wrCnt;
      sendFrame(5, 0); idle(2);
      lit("after_drop_writes", wrCnt - w0, 5);

      // Oversize frame is truncated
      clearStats(); w0 = wrCnt;
      sendFrame(1600, 0); idle(2);
      lit("trunc_writes", wrCnt - w0, MF);
      lit("trunc_tag", int'(lastData[9:8]), 3);
      lit("trunc_err", int'(cnt_err), 1);

      // FIFO full mid-frame
      clearStats(); w0 = wrCnt;
      for (int i = 1; i <= 110; i++) begin
         gFull = (i >= 100) && (i < 110);
         step(i <= 105, 8'(i), i == 1, i == 105, 0);
      end
      gFull = 0; idle(2);
      lit("full_writes", wrCnt - w0, 100);
      lit("full_term", int'(lastData), 10'h300);
      lit("full_err", int'(cnt_err), 1);

      // sof inside a frame aborts it
      clearStats(); w0 = wrCnt;
      for (int i = 1; i <= 40; i++)
         step(1, 8'(i), (i == 1) || (i == 30), i == 40, 0);
      idle(2);
      lit("abort_writes", wrCnt - w0, 30);
      lit("abort_term", int'(lastData), 10'h300);
      lit("abort_err", int'(cnt_err), 1);
      lit("abort_drop", int'(cnt_drop), 1);

      // Saturation, then clear alongside an eof
      clearStats();
      for (int i = 0; i < CMAX + 5; i++) step(1, 8'(i), 1, 1, 0);
      idle(1);
      lit("sat_ok", int'(cnt_ok), CMAX);
      gClr = 1; step(1, 8'h55, 1, 1, 0); gClr = 0; idle(1);
      lit("clr_vs_eof", int'(cnt_ok), 0);

      // Reset mid-frame discards the tail
      sendFrame(1, 0);
      for (int i = 1; i <= 10; i++) step(1, 8'(i), i == 1, 0, 0);
      doReset();
      w0 = wrCnt;
      for (int i = 1; i <= 10; i++) step(1, 8'(i), 0, i == 10, 0);
      idle(1);
      lit("rst_tail_writes", wrCnt - w0, 0);
      sendFrame(3, 0); idle(2);
      lit("rst_next_ok", int'(cnt_ok), 1);

      // Random traffic
      for (int f = 0; f < 250; f++) begin
         int n;
         bit er;
         n = $urandom_range(1, 80);
         er = ($urandom_range(0, 3) == 0);
         gNum = ($urandom_range(0, 3) == 0) ? $urandom_range(0, FD - 1)
                                            : $urandom_range(0, thr + 2);
         gClr = ($urandom_range(0, 60) == 0);
         for (int i = 1; i <= n; i++) begin
            bit ab;
            gFull = ($urandom_range(0, 63) == 0);
            ab = (i > 1) && ($urandom_range(0, 150) == 0);
            step(1, 8'($urandom), (i == 1) || ab, i == n,
                 er && (i == n));
            gClr = 0;
            if ($urandom_range(0, 7) == 0) idle(1);
         end
         gFull = ($urandom_range(0, 3) == 0);
         idle($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0)
            step(1, 8'($urandom), 0, $urandom_range(0, 1) == 1, 0);
         gFull = 0;
      end
      idle(4);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
      $finish;
   end

endmodule
